// File: rtl/mem_ops_pkg.sv
// Shared encodings for the MEM stage: memory op codes, access sizes,
// FSM state encoding and small decode helpers.
package mem_ops_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    // Access size from the op code; anything unrecognised is a word access.
    function automatic mem_size_e op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            OP_LW, OP_SW:         return SZ_WORD;
            default:              return SZ_WORD;
        endcase
    endfunction

    // Zero-extending loads.
    function automatic logic op_unsigned(input logic [5:0] op);
        return (op == OP_LBU) || (op == OP_LHU);
    endfunction

    // Halfwords need an even address, words a 4-byte aligned address.
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
        case (size)
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store byte enables / lane replication and
// load lane extraction with sign or zero extension.
module mem_align
    import mem_ops_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  store_be_o,
    output logic [31:0] store_wdata_o,
    output logic [31:0] load_data_o
);

    logic [1:0]  byte_lane;
    logic        half_hi;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Map the byte offset to a physical lane (lane 3 = bits[31:24]) and format data.
    always_comb begin
        byte_lane     = BIG_ENDIAN ? (2'd3 - offset_i) : offset_i;
        half_hi       = BIG_ENDIAN ? ~offset_i[1] : offset_i[1];
        lane_byte     = 8'h00;
        store_be_o    = 4'hF;
        store_wdata_o = store_data_i;
        load_data_o   = load_word_i;

        case (byte_lane)
            2'd0:    lane_byte = load_word_i[7:0];
            2'd1:    lane_byte = load_word_i[15:8];
            2'd2:    lane_byte = load_word_i[23:16];
            default: lane_byte = load_word_i[31:24];
        endcase
        lane_half = half_hi ? load_word_i[31:16] : load_word_i[15:0];

        case (size_i)
            SZ_BYTE: begin
                store_be_o    = 4'b0001 << byte_lane;
                store_wdata_o = {4{store_data_i[7:0]}};
                load_data_o   = unsigned_i ? {24'h0, lane_byte}
                                           : {{24{lane_byte[7]}}, lane_byte};
            end
            SZ_HALF: begin
                store_be_o    = half_hi ? 4'b1100 : 4'b0011;
                store_wdata_o = {2{store_data_i[15:0]}};
                load_data_o   = unsigned_i ? {16'h0, lane_half}
                                           : {{16{lane_half[15]}}, lane_half};
            end
            default: begin
                store_be_o    = 4'hF;
                store_wdata_o = store_data_i;
                load_data_o   = load_word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage. Non-memory instructions pass straight through to the
// registered writeback outputs. Loads/stores run a small IDLE->REQ->(WAIT)
// FSM against the data cache and stall IF..EXE until the access completes.
//
// Cache handshake: a request transfers on a cycle where DC_req_valid and
// DC_req_ready are both high; address, data, byte enables and we stay fixed
// from the cycle valid rises until that transfer. DC_resp_valid has no ready:
// it is taken only in WAIT and ignored in every other state.
module mem_stage
    import mem_ops_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       Instr1_IN,
    input  logic [31:0]       Instr1_PC_IN,
    input  logic [31:0]       ALU_result1_IN,
    input  logic [4:0]        WriteRegister1_IN,
    input  logic [31:0]       MemWriteData1_IN,
    input  logic              RegWrite1_IN,
    input  logic [5:0]        ALU_Control1_IN,
    input  logic              MemRead1_IN,
    input  logic              MemWrite1_IN,
    output logic              DC_req_valid,
    output logic              DC_req_we,
    output logic [ADDR_W-1:0] DC_req_addr,
    output logic [31:0]       DC_req_wdata,
    output logic [3:0]        DC_req_be,
    input  logic              DC_req_ready,
    input  logic              DC_resp_valid,
    input  logic [31:0]       DC_resp_rdata,
    output logic              STALL_OUT,
    output logic [31:0]       Instr1_OUT,
    output logic [31:0]       Instr1_PC_OUT,
    output logic [31:0]       WriteData1_OUT,
    output logic [4:0]        WriteRegister1_OUT,
    output logic              RegWrite1_OUT,
    output logic              MisalignFault_OUT,
    output logic [4:0]        BypassReg1_MEMEXE,
    output logic [31:0]       BypassData1_MEMEXE,
    output logic              BypassValid1_MEMEXE,
    output logic [1:0]        MemState_DBG_OUT
);

    mem_state_e        state_q;

    // Latched access, held while the request/response is in flight.
    logic              req_valid_q;
    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [31:0]       req_wdata_q;
    logic [3:0]        req_be_q;
    mem_size_e         size_q;
    logic              unsigned_q;
    logic [1:0]        off_q;
    logic [4:0]        rd_q;
    logic              regwrite_q;
    logic [31:0]       instr_q;
    logic [31:0]       pc_q;

    // Writeback registers.
    logic [31:0]       wb_instr_q;
    logic [31:0]       wb_pc_q;
    logic [31:0]       wb_data_q;
    logic [4:0]        wb_reg_q;
    logic              wb_regwrite_q;
    logic              wb_fault_q;

    // Decode of the instruction currently presented by EXE.
    logic              mem_op_in;
    mem_size_e         in_size;
    logic              in_unsigned;
    logic [1:0]        in_off;
    logic              in_misalign;
    logic              complete;

    // Formatter is shared: IDLE formats the incoming store, WAIT the returning load.
    logic [1:0]        al_size;
    logic              al_unsigned;
    logic [1:0]        al_off;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic [31:0]       al_load;

    assign mem_op_in   = MemRead1_IN | MemWrite1_IN;
    assign in_size     = op_size(ALU_Control1_IN);
    assign in_unsigned = op_unsigned(ALU_Control1_IN);
    assign in_off      = ALU_result1_IN[1:0];
    assign in_misalign = is_misaligned(in_size, in_off);

    assign al_size     = (state_q == ST_IDLE) ? in_size : size_q;
    assign al_unsigned = (state_q == ST_IDLE) ? in_unsigned : unsigned_q;
    assign al_off      = (state_q == ST_IDLE) ? in_off : off_q;

    mem_align #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_align (
        .size_i       (al_size),
        .unsigned_i   (al_unsigned),
        .offset_i     (al_off),
        .store_data_i (MemWriteData1_IN),
        .load_word_i  (DC_resp_rdata),
        .store_be_o   (al_be),
        .store_wdata_o(al_wdata),
        .load_data_o  (al_load)
    );

    // Completion is the cycle the access finishes; stall upstream until then.
    always_comb begin
        complete = 1'b0;
        case (state_q)
            ST_IDLE: complete = mem_op_in && in_misalign;
            ST_REQ:  complete = DC_req_ready && req_we_q;
            ST_WAIT: complete = DC_resp_valid;
            default: complete = 1'b0;
        endcase
        STALL_OUT = ((state_q != ST_IDLE) || mem_op_in) && !complete;
    end

    // FSM plus writeback registers; non-completing cycles send a bubble to WB.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            req_valid_q   <= 1'b0;
            req_we_q      <= 1'b0;
            req_addr_q    <= '0;
            req_wdata_q   <= '0;
            req_be_q      <= '0;
            size_q        <= SZ_BYTE;
            unsigned_q    <= 1'b0;
            off_q         <= '0;
            rd_q          <= '0;
            regwrite_q    <= 1'b0;
            instr_q       <= '0;
            pc_q          <= '0;
            wb_instr_q    <= '0;
            wb_pc_q       <= '0;
            wb_data_q     <= '0;
            wb_reg_q      <= '0;
            wb_regwrite_q <= 1'b0;
            wb_fault_q    <= 1'b0;
        end else begin
            wb_instr_q    <= '0;
            wb_pc_q       <= '0;
            wb_data_q     <= '0;
            wb_reg_q      <= '0;
            wb_regwrite_q <= 1'b0;
            wb_fault_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (!mem_op_in) begin
                        wb_instr_q    <= Instr1_IN;
                        wb_pc_q       <= Instr1_PC_IN;
                        wb_data_q     <= ALU_result1_IN;
                        wb_reg_q      <= WriteRegister1_IN;
                        wb_regwrite_q <= RegWrite1_IN;
                    end else if (in_misalign) begin
                        wb_instr_q <= Instr1_IN;
                        wb_pc_q    <= Instr1_PC_IN;
                        wb_reg_q   <= WriteRegister1_IN;
                        wb_fault_q <= 1'b1;
                    end else begin
                        req_valid_q <= 1'b1;
                        req_we_q    <= MemWrite1_IN;
                        req_addr_q  <= {ALU_result1_IN[ADDR_W-1:2], 2'b00};
                        req_wdata_q <= al_wdata;
                        req_be_q    <= al_be;
                        size_q      <= in_size;
                        unsigned_q  <= in_unsigned;
                        off_q       <= in_off;
                        rd_q        <= WriteRegister1_IN;
                        regwrite_q  <= RegWrite1_IN;
                        instr_q     <= Instr1_IN;
                        pc_q        <= Instr1_PC_IN;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (DC_req_ready) begin
                        req_valid_q <= 1'b0;
                        if (req_we_q) begin
                            wb_instr_q <= instr_q;
                            wb_pc_q    <= pc_q;
                            wb_reg_q   <= rd_q;
                            state_q    <= ST_IDLE;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (DC_resp_valid) begin
                        wb_instr_q    <= instr_q;
                        wb_pc_q       <= pc_q;
                        wb_data_q     <= al_load;
                        wb_reg_q      <= rd_q;
                        wb_regwrite_q <= regwrite_q;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    req_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign DC_req_valid        = req_valid_q;
    assign DC_req_we           = req_we_q;
    assign DC_req_addr         = req_addr_q;
    assign DC_req_wdata        = req_wdata_q;
    assign DC_req_be           = req_be_q;

    assign Instr1_OUT          = wb_instr_q;
    assign Instr1_PC_OUT       = wb_pc_q;
    assign WriteData1_OUT      = wb_data_q;
    assign WriteRegister1_OUT  = wb_reg_q;
    assign RegWrite1_OUT       = wb_regwrite_q;
    assign MisalignFault_OUT   = wb_fault_q;

    assign BypassReg1_MEMEXE   = wb_reg_q;
    assign BypassData1_MEMEXE  = wb_data_q;
    assign BypassValid1_MEMEXE = wb_regwrite_q;

    assign MemState_DBG_OUT    = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized mix against a
// byte-level reference model of loads, stores and stall timing.
module tb_mem_stage;

  localparam bit BE = 1'b1;

  logic        CLK;
  logic        RESET;
  logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
  logic [4:0]  WriteRegister1_IN;
  logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
  logic [5:0]  ALU_Control1_IN;
  logic        DC_req_valid, DC_req_we, DC_req_ready, DC_resp_valid;
  logic [31:0] DC_req_addr, DC_req_wdata, DC_resp_rdata;
  logic [3:0]  DC_req_be;
  logic        STALL_OUT;
  logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT, BypassData1_MEMEXE;
  logic [4:0]  WriteRegister1_OUT, BypassReg1_MEMEXE;
  logic        RegWrite1_OUT, MisalignFault_OUT, BypassValid1_MEMEXE;
  logic [1:0]  MemState_DBG_OUT;

  mem_stage #(.BIG_ENDIAN(BE), .ADDR_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN), .ALU_result1_IN(ALU_result1_IN),
    .WriteRegister1_IN(WriteRegister1_IN), .MemWriteData1_IN(MemWriteData1_IN),
    .RegWrite1_IN(RegWrite1_IN), .ALU_Control1_IN(ALU_Control1_IN),
    .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
    .DC_req_valid(DC_req_valid), .DC_req_we(DC_req_we), .DC_req_addr(DC_req_addr),
    .DC_req_wdata(DC_req_wdata), .DC_req_be(DC_req_be), .DC_req_ready(DC_req_ready),
    .DC_resp_valid(DC_resp_valid), .DC_resp_rdata(DC_resp_rdata),
    .STALL_OUT(STALL_OUT), .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
    .WriteData1_OUT(WriteData1_OUT), .WriteRegister1_OUT(WriteRegister1_OUT),
    .RegWrite1_OUT(RegWrite1_OUT), .MisalignFault_OUT(MisalignFault_OUT),
    .BypassReg1_MEMEXE(BypassReg1_MEMEXE), .BypassData1_MEMEXE(BypassData1_MEMEXE),
    .BypassValid1_MEMEXE(BypassValid1_MEMEXE), .MemState_DBG_OUT(MemState_DBG_OUT)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks;
  int n_errors;
  logic [31:0] exp_q[$];

  // Observations from the last run_op call.
  int          obs_stalls;
  logic        obs_seen, obs_stable, obs_we;
  logic [31:0] obs_addr, obs_wdata, obs_instr, obs_pc;
  logic [3:0]  obs_be;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      default:             return 4;
    endcase
  endfunction

  // Byte at memory offset k within a word.
  function automatic logic [7:0] m_byte(input logic [31:0] w, input int k);
    if (BE) return w[31-8*k -: 8];
    return w[8*k +: 8];
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [1:0] off, input logic [31:0] rdata);
    int n;
    logic [31:0] v;
    n = m_size(op);
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      if (BE) v = (v << 8) | {24'h0, m_byte(rdata, int'(off) + i)};
      else    v = v | ({24'h0, m_byte(rdata, int'(off) + i)} << (8 * i));
    end
    if (n < 4 && op != 6'h24 && op != 6'h25 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [1:0] off);
    logic [3:0] be;
    int lane;
    be = 4'h0;
    for (int i = 0; i < m_size(op); i++) begin
      lane = BE ? 3 - (int'(off) + i) : int'(off) + i;
      be[lane] = 1'b1;
    end
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] d);
    if (m_size(op) == 1) return {4{d[7:0]}};
    if (m_size(op) == 2) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic m_misalign(input logic [5:0] op, input logic [1:0] off);
    return (int'(off) % m_size(op)) != 0;
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    Instr1_IN = 0; Instr1_PC_IN = 0; ALU_result1_IN = 0; MemWriteData1_IN = 0;
    WriteRegister1_IN = 0; RegWrite1_IN = 0; ALU_Control1_IN = 0;
    MemRead1_IN = 0; MemWrite1_IN = 0;
  endtask

  // Presents one instruction (called just after a posedge), acts as the cache,
  // holds the instruction while stalled, returns just after the completion edge.
  task automatic run_op(input logic [5:0] op, input logic mr, input logic mw, input logic rw,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                        input int rdy_dly, input int resp_dly, input logic [31:0] rdata,
                        input logic noise);
    int req_cyc, wait_cyc;
    logic accepted, done;
    req_cyc = 0; wait_cyc = 0; accepted = 0; done = 0;
    obs_stalls = 0; obs_seen = 0; obs_stable = 1; obs_we = 0;
    obs_addr = 0; obs_be = 0; obs_wdata = 0;
    obs_instr = $urandom; obs_pc = $urandom;
    Instr1_IN = obs_instr; Instr1_PC_IN = obs_pc; ALU_result1_IN = alu;
    MemWriteData1_IN = wd; WriteRegister1_IN = rd; RegWrite1_IN = rw;
    ALU_Control1_IN = op; MemRead1_IN = mr; MemWrite1_IN = mw;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge CLK);
      DC_req_ready = 0; DC_resp_valid = 0; DC_resp_rdata = $urandom;
      if (DC_req_valid) begin
        if (!obs_seen) begin
          obs_seen = 1; obs_addr = DC_req_addr; obs_be = DC_req_be;
          obs_wdata = DC_req_wdata; obs_we = DC_req_we;
        end else if (obs_addr !== DC_req_addr || obs_be !== DC_req_be ||
                     obs_wdata !== DC_req_wdata || obs_we !== DC_req_we) begin
          obs_stable = 0;
        end
        if (req_cyc >= rdy_dly) DC_req_ready = 1;
        req_cyc++;
      end else if (accepted) begin
        if (wait_cyc >= resp_dly) begin DC_resp_valid = 1; DC_resp_rdata = rdata; end
        wait_cyc++;
      end else if (noise && $urandom_range(0, 1) == 1) begin
        DC_resp_valid = 1;
      end
      #1;
      if (STALL_OUT) obs_stalls++; else done = 1;
      if (DC_req_valid && DC_req_ready && !DC_req_we) accepted = 1;
      @(posedge CLK); #1;
      DC_req_ready = 0; DC_resp_valid = 0;
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL op_timeout: op %h still stalled after 64 cycles, required completion", op);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET = 1; idle_inputs(); DC_req_ready = 0; DC_resp_valid = 0; DC_resp_rdata = 0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if ({WriteData1_OUT, WriteRegister1_OUT, RegWrite1_OUT, MisalignFault_OUT, Instr1_OUT, Instr1_PC_OUT} !== '0) begin
      n_errors++; $display("FAIL reset_wb: data %h reg %0d rw %b fault %b, required all 0",
                           WriteData1_OUT, WriteRegister1_OUT, RegWrite1_OUT, MisalignFault_OUT);
    end
    n_checks++;
    if ({BypassData1_MEMEXE, BypassReg1_MEMEXE, BypassValid1_MEMEXE, DC_req_valid, STALL_OUT} !== '0) begin
      n_errors++; $display("FAIL reset_bypass: byp %h/%0d/%b req_valid %b stall %b, required 0",
                           BypassData1_MEMEXE, BypassReg1_MEMEXE, BypassValid1_MEMEXE, DC_req_valid, STALL_OUT);
    end
    RESET = 0;
    // A stray response while idle must be dropped.
    DC_resp_valid = 1; DC_resp_rdata = 32'h5555_AAAA;
    @(posedge CLK); #1;
    DC_resp_valid = 0;
    n_checks++;
    if (RegWrite1_OUT !== 1'b0 || WriteData1_OUT !== 32'h0 || STALL_OUT !== 1'b0) begin
      n_errors++; $display("FAIL idle_resp_ignored: rw %b data %h stall %b, required 0/0/0",
                           RegWrite1_OUT, WriteData1_OUT, STALL_OUT);
    end
  endtask

  task automatic test_alu();
    run_op(6'h01, 0, 0, 1, 5'd5, 32'h1234, 32'h0, 0, 0, 0, 0);
    n_checks++;
    if (WriteData1_OUT !== 32'h1234 || WriteRegister1_OUT !== 5'd5 || RegWrite1_OUT !== 1'b1) begin
      n_errors++; $display("FAIL alu_wb: data %h reg %0d rw %b, required 00001234/5/1",
                           WriteData1_OUT, WriteRegister1_OUT, RegWrite1_OUT);
    end
    n_checks++;
    if (BypassData1_MEMEXE !== 32'h1234 || BypassReg1_MEMEXE !== 5'd5 || BypassValid1_MEMEXE !== 1'b1) begin
      n_errors++; $display("FAIL alu_bypass: %h/%0d/%b, required 00001234/5/1",
                           BypassData1_MEMEXE, BypassReg1_MEMEXE, BypassValid1_MEMEXE);
    end
    n_checks++;
    if (obs_stalls !== 0 || Instr1_OUT !== obs_instr || Instr1_PC_OUT !== obs_pc) begin
      n_errors++; $display("FAIL alu_pass: stalls %0d instr %h pc %h, required 0 %h %h",
                           obs_stalls, Instr1_OUT, Instr1_PC_OUT, obs_instr, obs_pc);
    end
  endtask

  task automatic test_load_word();
    run_op(6'h23, 1, 0, 1, 5'd9, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);
    n_checks++;
    if (!obs_seen || obs_addr !== 32'h100 || obs_be !== 4'hF || obs_we !== 1'b0) begin
      n_errors++; $display("FAIL lw_req: seen %b addr %h be %h we %b, required 1 00000100 f 0",
                           obs_seen, obs_addr, obs_be, obs_we);
    end
    n_checks++;
    if (WriteData1_OUT !== 32'hDEAD_BEEF || RegWrite1_OUT !== 1'b1 || WriteRegister1_OUT !== 5'd9) begin
      n_errors++; $display("FAIL lw_wb: data %h rw %b reg %0d, required deadbeef 1 9",
                           WriteData1_OUT, RegWrite1_OUT, WriteRegister1_OUT);
    end
    n_checks++;
    if (obs_stalls !== 2) begin
      n_errors++; $display("FAIL lw_stall: %0d cycles, required 2", obs_stalls);
    end
  endtask

  task automatic test_load_bytes();
    logic [5:0]  ops [3]  = '{6'h20, 6'h24, 6'h21};
    logic [31:0] adrs [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] exps [3] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'h0000_33F0};
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], 1, 0, 1, 5'd3, adrs[i], 32'h0, 1, 1, 32'h1122_33F0, 0);
      n_checks++;
      if (WriteData1_OUT !== exps[i] || obs_stalls !== 4) begin
        n_errors++; $display("FAIL subword_load[%0d]: data %h stalls %0d, required %h 4",
                             i, WriteData1_OUT, obs_stalls, exps[i]);
      end
    end
  endtask

  task automatic test_store_byte();
    run_op(6'h28, 0, 1, 1, 5'd4, 32'h101, 32'h0000_00AB, 3, 0, 32'h0, 0);
    n_checks++;
    if (obs_be !== 4'b0100 || obs_wdata !== 32'hABAB_ABAB || obs_we !== 1'b1 || obs_addr !== 32'h100) begin
      n_errors++; $display("FAIL sb_req: be %b wdata %h we %b addr %h, required 0100 abababab 1 00000100",
                           obs_be, obs_wdata, obs_we, obs_addr);
    end
    n_checks++;
    if (!obs_stable || obs_stalls !== 4 || RegWrite1_OUT !== 1'b0) begin
      n_errors++; $display("FAIL sb_timing: stable %b stalls %0d rw %b, required 1 4 0",
                           obs_stable, obs_stalls, RegWrite1_OUT);
    end
  endtask

  task automatic test_misalign();
    logic [5:0]  ops [3]  = '{6'h23, 6'h29, 6'h25};
    logic [31:0] adrs [3] = '{32'h102, 32'h101, 32'h203};
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], ops[i] != 6'h29, ops[i] == 6'h29, 1, 5'd6, adrs[i], 32'h77, 0, 0, 32'h0, 0);
      n_checks++;
      if (obs_seen || MisalignFault_OUT !== 1'b1 || RegWrite1_OUT !== 1'b0 || obs_stalls !== 0) begin
        n_errors++; $display("FAIL misalign[%0d]: req %b fault %b rw %b stalls %0d, required 0 1 0 0",
                             i, obs_seen, MisalignFault_OUT, RegWrite1_OUT, obs_stalls);
      end
    end
    run_op(6'h01, 0, 0, 1, 5'd2, 32'hABCD, 32'h0, 0, 0, 0, 0);
    n_checks++;
    if (MisalignFault_OUT !== 1'b0 || RegWrite1_OUT !== 1'b1 || WriteData1_OUT !== 32'hABCD) begin
      n_errors++; $display("FAIL fault_pulse: fault %b rw %b data %h, required 0 1 0000abcd",
                           MisalignFault_OUT, RegWrite1_OUT, WriteData1_OUT);
    end
  endtask

  task automatic test_reset_in_wait();
    Instr1_IN = 32'h1; Instr1_PC_IN = 32'h4; ALU_result1_IN = 32'h200; MemWriteData1_IN = 0;
    WriteRegister1_IN = 5'd8; RegWrite1_IN = 1; ALU_Control1_IN = 6'h23;
    MemRead1_IN = 1; MemWrite1_IN = 0;
    @(posedge CLK); #1;
    @(negedge CLK);
    n_checks++;
    if (DC_req_valid !== 1'b1) begin
      n_errors++; $display("FAIL rst_wait_req: req_valid %b, required 1", DC_req_valid);
    end
    DC_req_ready = 1;
    @(posedge CLK); #1;
    DC_req_ready = 0;
    @(negedge CLK);
    RESET = 1;
    @(posedge CLK); #1;
    RESET = 0; idle_inputs();
    DC_resp_valid = 1; DC_resp_rdata = 32'hCAFE_F00D;
    @(negedge CLK);
    n_checks++;
    if (DC_req_valid !== 1'b0 || STALL_OUT !== 1'b0 || RegWrite1_OUT !== 1'b0 || WriteData1_OUT !== 32'h0) begin
      n_errors++; $display("FAIL rst_wait_clear: req %b stall %b rw %b data %h, required 0 0 0 0",
                           DC_req_valid, STALL_OUT, RegWrite1_OUT, WriteData1_OUT);
    end
    @(posedge CLK); #1;
    DC_resp_valid = 0;
    n_checks++;
    if (RegWrite1_OUT !== 1'b0 || WriteData1_OUT !== 32'h0 || WriteRegister1_OUT !== 5'd0) begin
      n_errors++; $display("FAIL rst_wait_drop: rw %b data %h reg %0d, required 0 0 0",
                           RegWrite1_OUT, WriteData1_OUT, WriteRegister1_OUT);
    end
    run_op(6'h01, 0, 0, 1, 5'd7, 32'h55, 32'h0, 0, 0, 0, 0);
    n_checks++;
    if (WriteData1_OUT !== 32'h55 || WriteRegister1_OUT !== 5'd7 || RegWrite1_OUT !== 1'b1 || obs_stalls !== 0) begin
      n_errors++; $display("FAIL rst_wait_next: data %h reg %0d rw %b stalls %0d, required 55 7 1 0",
                           WriteData1_OUT, WriteRegister1_OUT, RegWrite1_OUT, obs_stalls);
    end
  endtask

  // Random back-to-back mix of ALU ops, loads and stores with random cache delays.
  task automatic test_random();
    logic [5:0]  op;
    logic        mr, mw, rw, mis, is_mem;
    logic [31:0] alu, wd, rdata, exp_d;
    logic [4:0]  rd;
    int          kind, rdy, rsp, n, exp_st;
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 11);
      mr = 0; mw = 0;
      case (kind)
        0: begin op = 6'h20; mr = 1; end
        1: begin op = 6'h21; mr = 1; end
        2: begin op = 6'h23; mr = 1; end
        3: begin op = 6'h24; mr = 1; end
        4: begin op = 6'h25; mr = 1; end
        5: begin op = 6'h28; mw = 1; end
        6: begin op = 6'h29; mw = 1; end
        7: begin op = 6'h2B; mw = 1; end
        8: begin op = 6'h3F; mr = 1; end
        9: begin op = 6'h3E; mw = 1; end
        default: op = 6'($urandom_range(0, 31));
      endcase
      is_mem = mr | mw;
      alu = $urandom; wd = $urandom; rdata = $urandom; rd = 5'($urandom_range(0, 31));
      rw = 1'($urandom_range(0, 1));
      rdy = $urandom_range(0, 3); rsp = $urandom_range(0, 3);
      n = m_size(op);
      if ($urandom_range(0, 3) != 0) alu = alu & ~(32'(n) - 32'd1);
      mis = is_mem && m_misalign(op, alu[1:0]);
      exp_st = (!is_mem || mis) ? 0 : (mw ? 1 + rdy : 2 + rdy + rsp);
      if (!is_mem) exp_q.push_back(alu);
      else if (mr && !mis) exp_q.push_back(m_load(op, alu[1:0], rdata));
      run_op(op, mr, mw, rw, rd, alu, wd, rdy, rsp, rdata, 1'b1);
      n_checks++;
      if (obs_stalls != exp_st || obs_seen !== (is_mem && !mis) || !obs_stable) begin
        n_errors++; $display("FAIL rnd_timing[%0d] op %h: stalls %0d req %b stable %b, required %0d %b 1",
                             it, op, obs_stalls, obs_seen, obs_stable, exp_st, is_mem && !mis);
      end
      if (obs_seen) begin
        n_checks++;
        if (obs_addr !== {alu[31:2], 2'b00} || obs_we !== mw) begin
          n_errors++; $display("FAIL rnd_req[%0d]: addr %h we %b, required %h %b",
                               it, obs_addr, obs_we, {alu[31:2], 2'b00}, mw);
        end
        if (mw) begin
          n_checks++;
          if (obs_be !== m_be(op, alu[1:0]) || obs_wdata !== m_wdata(op, wd)) begin
            n_errors++; $display("FAIL rnd_store[%0d] op %h off %0d: be %b wdata %h, required %b %h",
                                 it, op, alu[1:0], obs_be, obs_wdata, m_be(op, alu[1:0]), m_wdata(op, wd));
          end
        end
      end
      n_checks++;
      if (MisalignFault_OUT !== mis || RegWrite1_OUT !== ((!is_mem || (mr && !mis && !mw)) ? rw : 1'b0)) begin
        n_errors++; $display("FAIL rnd_flags[%0d] op %h: fault %b rw %b, required fault %b",
                             it, op, MisalignFault_OUT, RegWrite1_OUT, mis);
      end
      if (!is_mem || (mr && !mis)) begin
        exp_d = exp_q.pop_front();
        n_checks++;
        if (WriteData1_OUT !== exp_d || BypassData1_MEMEXE !== exp_d || BypassReg1_MEMEXE !== rd ||
            WriteRegister1_OUT !== rd || Instr1_OUT !== obs_instr) begin
          n_errors++; $display("FAIL rnd_wb[%0d] op %h: data %h byp %h reg %0d, required %h reg %0d",
                               it, op, WriteData1_OUT, BypassData1_MEMEXE, WriteRegister1_OUT, exp_d, rd);
        end
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0; n_errors = 0;
    test_reset();
    test_alu();
    test_load_word();
    test_load_bytes();
    test_store_byte();
    test_misalign();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
